// File: rtl/icache.sv
// ============================================================================
// icache : direct-mapped read-only instruction cache, 2-word blocks, 5-state fill FSM
// rev 1.0
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH0 = 3'd1;
  localparam logic [2:0] GAP0   = 3'd2;
  localparam logic [2:0] FETCH1 = 3'd3;
  localparam logic [2:0] GAP1   = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [SETS-1:0]    valid;
  logic [SETS*TW-1:0] tags;
  logic [SETS*32-1:0] word0;
  logic [SETS*32-1:0] word1;
  logic [TW-1:0]      miss_tag;
  logic [IW-1:0]      miss_idx;

  logic [TW-1:0]      req_tag;
  logic [IW-1:0]      req_idx;
  logic               req_off;
  logic               tag_match;
  logic               hit;
  logic               miss;
  logic               unused_addr_bits;

  assign req_tag          = imemaddr[31:3+IW];
  assign req_idx          = imemaddr[2+IW:3];
  assign req_off          = imemaddr[2];
  assign unused_addr_bits = ^imemaddr[1:0];

  assign tag_match = valid[req_idx] && (tags[req_idx*TW +: TW] == req_tag);
  assign hit       = (state == IDLE) && imemREN && !iflush && tag_match;
  assign miss      = (state == IDLE) && imemREN && !iflush && !tag_match;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (iflush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (miss)   state_nxt = FETCH0;
        FETCH0:  if (!iwait) state_nxt = GAP0;
        GAP0:                state_nxt = FETCH1;
        FETCH1:  if (!iwait) state_nxt = GAP1;
        GAP1:                state_nxt = IDLE;
        default:             state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ihit     = hit;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (hit) imemload = req_off ? word1[req_idx*32 +: 32] : word0[req_idx*32 +: 32];
    case (state)
      FETCH0: begin
        iREN  = 1'b1;
        iaddr = {miss_tag, miss_idx, 1'b0, 2'b00};
      end
      FETCH1: begin
        iREN  = 1'b1;
        iaddr = {miss_tag, miss_idx, 1'b1, 2'b00};
      end
      default: ;
    endcase
  end

  // Valid is dropped when a fill starts so a half-written block can never hit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid    <= '0;
      tags     <= '0;
      word0    <= '0;
      word1    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else if (iflush) begin
      valid <= '0;
    end else begin
      case (state)
        IDLE: if (miss) begin
          miss_tag       <= req_tag;
          miss_idx       <= req_idx;
          valid[req_idx] <= 1'b0;
        end
        FETCH0: if (!iwait) word0[miss_idx*32 +: 32] <= iload;
        FETCH1: if (!iwait) begin
          word1[miss_idx*32 +: 32] <= iload;
          tags[miss_idx*TW +: TW]  <= miss_tag;
          valid[miss_idx]          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have parameter: SETS, 16, number of direct-mapped frames (power of 2, ≥2); index width IW = log2(SETS).
REQ-002 The block SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port: nRST  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port: imemREN  input  1  datapath instruction read request.
REQ-005 The block SHALL have port: imemaddr  input  32  datapath fetch byte address (word aligned).
REQ-006 The block SHALL have port: iflush  input  1  invalidate all frames.
REQ-007 The block SHALL have port: ihit  output  1  imemload valid this cycle.
REQ-008 The block SHALL have port: imemload  output  32  instruction word to datapath.
REQ-009 The block SHALL have port: iREN  output  1  read request to memory controller.
REQ-010 The block SHALL have port: iaddr  output  32  word address to memory controller.
REQ-011 The block SHALL have port: iwait  input  1  memory controller stall; 0 = iload valid.
REQ-012 The block SHALL have port: iload  input  32  word from memory controller.

Function
REQ-013 Address split SHALL be: tag = imemaddr[31:3+IW], index = imemaddr[2+IW:3], blkoff = imemaddr[2], bits[1:0] ignored.
REQ-014 Each frame SHALL hold valid (1b), tag, and two 32-bit words; block = 8 bytes.
REQ-015 Hit SHALL be combinational: ihit = 1 when state==IDLE, imemREN=1, iflush=0, frame[index].valid=1 and tag matches; imemload = frame[index].word[blkoff] on hit, else 0.
REQ-016 FSM states SHALL be IDLE, FETCH0, GAP0, FETCH1, GAP1.
REQ-017 IDLE: on imemREN=1 with miss and iflush=0, SHALL latch tag/index into a miss register and go to FETCH0; iREN=0 in IDLE.
REQ-018 FETCH0: iREN=1, iaddr = {miss tag, miss index, 1'b0, 2'b00}; on iwait=0 SHALL write iload to word0 of the miss frame and go to GAP0.
REQ-019 GAP0: iREN=0 for exactly one cycle (lets the controller leave its fetched state), then FETCH1; iwait ignored in GAP states.
REQ-020 FETCH1: iREN=1, iaddr = {miss tag, miss index, 1'b1, 2'b00}; on iwait=0 SHALL write word1, write tag, set valid, go to GAP1.
REQ-021 GAP1: iREN=0 for one cycle, then IDLE; earliest hit on the filled block is the cycle after GAP1.
REQ-022 The frame's valid bit SHALL be cleared on entry to FETCH0 and set only in FETCH1 completion; no partial block ever hits.
REQ-023 ihit SHALL be 0 in every state other than IDLE.
REQ-024 Changes of imemREN/imemaddr during a fill SHALL NOT abort or redirect the fill; the request is re-evaluated in IDLE.
REQ-025 iwait=0 while in FETCH0/FETCH1 SHALL be consumed once; a held-low iwait yields one write per FETCH state.
REQ-026 iflush=1 in any state SHALL clear all valid bits next edge and force IDLE; an in-progress fill is abandoned (iREN=0 next cycle); flush outranks a simultaneous miss or fill completion.
REQ-027 Miss to an index holding a valid different tag SHALL overwrite (evict) it; no writeback (read-only cache).

Reset
REQ-028 On nRST=0, asynchronously: state=IDLE, all valid=0, tags/words=0, miss register=0; outputs iREN=0, iaddr=0, ihit=0, imemload=0.
REQ-029 Reset asserted mid-fill SHALL abandon the fill with iREN=0 immediately; no frame becomes valid.

Verification
REQ-030 Cold miss: imemREN=1, imemaddr=0x00000040, controller returns 0xAAAA0001/0xAAAA0002 after 2 wait cycles each -> iREN/iaddr 0x40, GAP (iREN=0), iREN/iaddr 0x44, GAP, then ihit=1 imemload=0xAAAA0001.
REQ-031 Spatial hit: after REQ-030, imemaddr=0x00000044 -> ihit=1 same cycle, imemload=0xAAAA0002, iREN stays 0.
REQ-032 Conflict: after REQ-030, imemaddr=0x00000440 (index 8) -> miss, fill from 0x440/0x444; then 0x40 misses again.
REQ-033 Flush: fill 0x40, pulse iflush one cycle -> next cycle 0x40 misses (iREN=1, iaddr=0x40); flush during FETCH1 -> iREN=0 next cycle, frame invalid.
REQ-034 Reset mid-fill: nRST low during FETCH1 -> iREN=0 immediately; after release 0x40 misses.
REQ-035 Held iwait=0 through FETCH0 -> word0 written once, iREN=0 for exactly one GAP0 cycle, iaddr=0x44 in FETCH1.
